// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS core, one ALU/register file, unified req/ready memory port.
// Define MIPS_MC_BNE_EN to add bne (opcode 000101); otherwise that opcode traps.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;
  state_t      state, dec_next;
  logic [31:0] ir, a, b, alu_out, mdr, imm_ext, alu_r, addr_full;
  logic [31:0] rf [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        alu_ok, take;
  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};
  always_comb begin
    alu_r  = '0;
    alu_ok = 1'b1;
    case (funct)
      6'b100000: alu_r = a + b;
      6'b100010: alu_r = a - b;
      6'b100100: alu_r = a & b;
      6'b100101: alu_r = a | b;
      6'b101010: alu_r = {31'b0, $signed(a) < $signed(b)};
      6'b000000: alu_r = b << shamt;
      6'b000010: alu_r = b >> shamt;
      default:   alu_ok = 1'b0;
    endcase
  end
  always_comb begin
    dec_next = TRAP;
    case (op)
      6'b100011, 6'b101011: dec_next = MEMADR;
      6'b000000:            dec_next = EXEC;
      6'b000100:            dec_next = BRANCH;
`ifdef MIPS_MC_BNE_EN
      6'b000101:            dec_next = BRANCH;
`endif
      6'b001000:            dec_next = ADDIEX;
      6'b000010:            dec_next = JUMP;
      default:              dec_next = TRAP;
    endcase
  end
`ifdef MIPS_MC_BNE_EN
  assign take = (op == 6'b000101) ? (a != b) : (a == b);
`else
  assign take = a == b;
`endif
  // Reset gates the request combinationally so an in-flight transaction drops at once.
  assign mem_req   = ~reset & (state == FETCH || state == MEMRD || state == MEMWR);
  assign mem_we    = state == MEMWR;
  assign addr_full = (state == FETCH) ? pc : alu_out;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b;
  assign halted    = state == TRAP;
  assign retire    = state == MEMWB || state == ALUWB || state == BRANCH || state == ADDIWB ||
                     state == JUMP || (state == MEMWR && mem_ready);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc + (imm_ext << 2);
          state   <= dec_next;
        end
        MEMADR: begin
          alu_out <= a + imm_ext;
          state   <= (op == 6'b101011) ? MEMWR : MEMRD;
        end
        MEMRD: if (mem_ready) begin
          mdr   <= mem_rdata;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rt != 5'd0) rf[rt] <= mdr;
          state <= FETCH;
        end
        MEMWR: if (mem_ready) state <= FETCH;
        EXEC: begin
          alu_out <= alu_r;
          state   <= alu_ok ? ALUWB : TRAP;
        end
        ALUWB: begin
          if (rd != 5'd0) rf[rd] <= alu_out;
          state <= FETCH;
        end
        BRANCH: begin
          if (take) pc <= alu_out;
          state <= FETCH;
        end
        ADDIEX: begin
          alu_out <= a + imm_ext;
          state   <= ADDIWB;
        end
        ADDIWB: begin
          if (rt != 5'd0) rf[rt] <= alu_out;
          state <= FETCH;
        end
        JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= FETCH;
        end
        default: state <= TRAP;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: random programs run against an instruction-level model with random wait states.
module tb_mips_multicycle;
  localparam logic [31:0] BASE = 32'h100;
  logic        clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic        mem_req, mem_we, retire, halted;
  logic [31:0] mem_addr, mem_wdata, pc, mem_rdata = '0;
  logic [31:0] img [1024], tmem [1024], mref [1024], regs [32], mpc;
  int          checks = 0, errors = 0;

  mips_multicycle #(.RESET_PC(BASE), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[11:2]);
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  // Architectural effect of one instruction at mpc.
  task automatic model_step(output int cpi, output bit st, output logic [31:0] sa, output logic [31:0] sd, output bit trap);
    logic [31:0] ins, x, y, se, npc, v;
    int d;
    ins = mref[widx(mpc)];
    x = regs[ins[25:21]];
    y = regs[ins[20:16]];
    se = 32'($signed(ins[15:0]));
    npc = mpc + 4;
    st = 0; trap = 0; cpi = 3; d = 0; v = 0; sa = 0; sd = 0;
    case (ins[31:26])
      6'h00: begin
        cpi = 4;
        d = int'(ins[15:11]);
        case (ins[5:0])
          6'h20: v = x + y;
          6'h22: v = x - y;
          6'h24: v = x & y;
          6'h25: v = x | y;
          6'h2a: v = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          6'h00: v = y << ins[10:6];
          6'h02: v = y >> ins[10:6];
          default: trap = 1;
        endcase
      end
      6'h08: begin cpi = 4; d = int'(ins[20:16]); v = x + se; end
      6'h23: begin cpi = 5; d = int'(ins[20:16]); v = mref[widx(x + se)]; end
      6'h2b: begin cpi = 4; st = 1; sa = x + se; sd = y; mref[widx(sa)] = y; end
      6'h04: if (x == y) npc = npc + (se << 2);
`ifdef MIPS_MC_BNE_EN
      6'h05: if (x != y) npc = npc + (se << 2);
`endif
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: trap = 1;
    endcase
    if (!trap) begin
      if (d != 0) regs[d] = v;
      mpc = npc;
    end
  endtask

  task automatic build_prog();
    logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
    int p = 64, t;
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    for (int r = 1; r <= 8; r++) img[p++] = itype(6'h08, 0, r, 16'($urandom));
    for (int k = 0; k < 24; k++) begin
      t = $urandom_range(0, 9);
      if (t == 0)
        img[p++] = itype(6'h08, $urandom_range(0, 8), $urandom_range(0, 8), 16'($urandom));
      else if (t < 8)
        img[p++] = rtype($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8),
                         $urandom_range(0, 31), fns[t-1]);
      else
        img[p++] = itype((t == 8) ? 6'h2b : 6'h23, 0, $urandom_range(0, 8),
                         16'(32'h800 + 4 * $urandom_range(0, 15)));
    end
    img[p++] = itype(6'h04, 3, 3, 16'd1);
    img[p++] = itype(6'h08, 0, 1, 16'h1111);
    img[p++] = itype(6'h04, 1, 2, 16'd1);
    img[p++] = itype(6'h08, 2, 2, 16'd3);
    img[p] = {6'h02, 26'(p + 2)};
    p++;
    img[p++] = itype(6'h08, 0, 1, 16'h2222);
    for (int r = 1; r <= 8; r++) img[p++] = itype(6'h2b, 0, r, 16'(32'h900 + 4 * r));
    img[p++] = itype(6'h08, 0, 1, 16'd5);
    img[p++] = itype(6'h08, 0, 2, 16'd7);
    img[p++] = itype(6'h05, 1, 2, 16'd2);
    img[p++] = itype(6'h08, 0, 3, 16'd1);
    img[p++] = itype(6'h08, 0, 3, 16'd2);
    img[p++] = 32'hFC00_0000;
  endtask

  task automatic load();
    tmem = img;
    mref = img;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    mpc = BASE;
  endtask

  // Entered just after reset release; acts as the memory and checks each retire.
  task automatic run_prog(input bit waits);
    int cyc = 0, wn = 0, cpi, idx;
    bit pend = 0, done = 0, st, trap, wr = 0, pw = 0;
    logic [31:0] sa, sd, wa = '0, wd = '0, pa = '0, pdat = '0;
    logic pwe = 1'b0;
    for (int n = 0; n < 20000 && !done; n++) begin
      mem_ready = waits ? ($urandom_range(0, 2) != 0) : 1'b1;
      idx = widx(mem_addr);
      mem_rdata = tmem[idx];
      #1;
      if (pend) begin
        chk("pc_after_retire", pc, mpc);
        pend = 0;
      end
      if (pw) begin
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, pa);
        chk("hold_we", mem_we, pwe);
        chk("hold_wdata", mem_wdata, pdat);
      end
      pw = mem_req && !mem_ready;
      pa = mem_addr; pwe = mem_we; pdat = mem_wdata;
      cyc++;
      if (pw) wn++;
      if (mem_req && mem_ready && mem_we) begin
        wr = 1; wa = mem_addr; wd = mem_wdata;
        tmem[idx] = mem_wdata;
      end
      if (retire) begin
        model_step(cpi, st, sa, sd, trap);
        chk("retire_legal", trap, 0);
        chk("cpi", cyc - wn, cpi);
        chk("store_seen", wr, st);
        if (st) begin
          chk("store_addr", wa, sa);
          chk("store_data", wd, sd);
        end
        cyc = 0; wn = 0; wr = 0; pend = 1;
      end else if (halted) begin
        model_step(cpi, st, sa, sd, trap);
        chk("trap_expected", trap, 1);
        chk("trap_cycles", cyc - wn, 3);
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    chk("halt_reached", done, 1);
  endtask

  task automatic release_and_check();
    load();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, BASE);
    chk("first_we", mem_we, 0);
  endtask

  initial begin
    build_prog();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", mem_req, 0);
    chk("reset_retire", retire, 0);
    chk("reset_halted", halted, 0);
    chk("reset_pc", pc, BASE);
    release_and_check();
    run_prog(1'b1);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("halt_sticky", halted, 1);
      chk("halt_no_req", mem_req, 0);
      chk("halt_no_retire", retire, 0);
    end
    for (int r = 1; r <= 8; r++) chk("final_mem", tmem[576 + r], mref[576 + r]);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_clear_halted", halted, 0);
    release_and_check();
    run_prog(1'b0);
    for (int r = 1; r <= 8; r++) chk("final_mem_nowait", tmem[576 + r], mref[576 + r]);
    @(negedge clk);
    reset = 1'b1;
    release_and_check();
    repeat (3) @(negedge clk);
    #1;
    chk("stall_req", mem_req, 1);
    chk("stall_addr", mem_addr, BASE);
    #2 reset = 1'b1;
    #1;
    chk("abort_req", mem_req, 0);
    chk("abort_pc", pc, BASE);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
